// File: rtl/clock_recovery_sequencer.sv
// Sequencing controller for clock_recovery: acquires lock, frames traffic on short pauses,
// counts frequency violations, and backs off / retries / halts on faults.
module clock_recovery_sequencer #(
    parameter int CYCLE_W         = 8,
    parameter int ACQ_TIMEOUT     = 1024,
    parameter int BACKOFF_CYCLES  = 64,
    parameter int FREQ_VIOL_LIMIT = 4,
    parameter int MAX_RETRIES     = 3
) (
    input  logic               clk,
    input  logic               async_rst_n,
    input  logic               clk_en,
    input  logic               ctrl_enable_i,
    input  logic [CYCLE_W-1:0] preemptive_cfg_i,
    input  logic               pause_start_detected_i,
    input  logic               short_pause_complete_i,
    input  logic               long_pause_complete_i,
    input  logic               data_overflow_violation_i,
    input  logic               data_underflow_violation_i,
    input  logic               frequency_violation_i,
    output logic               recovery_enable_o,
    output logic [CYCLE_W-1:0] preemptive_output_cycle_count_o,
    output logic               link_locked_o,
    output logic               frame_end_o,
    output logic               link_idle_o,
    output logic               fault_o,
    output logic [1:0]         fault_code_o,
    output logic [1:0]         retry_count_o,
    output logic [2:0]         state_o
);

    typedef enum logic [2:0] {
        ST_DISABLED = 3'd0,
        ST_CONFIG   = 3'd1,
        ST_ACQUIRE  = 3'd2,
        ST_LOCKED   = 3'd3,
        ST_FAULT    = 3'd4,
        ST_HALT     = 3'd5
    } state_t;

    localparam int ACQ_W = (ACQ_TIMEOUT > 1) ? $clog2(ACQ_TIMEOUT) : 1;
    localparam int BO_W  = (BACKOFF_CYCLES > 1) ? $clog2(BACKOFF_CYCLES) : 1;
    localparam int FC_W  = $clog2(FREQ_VIOL_LIMIT + 1);
    // Retry counter keeps one value beyond MAX_RETRIES so the halt decision is exact
    // even though the visible count saturates at 3.
    localparam int RW    = ($clog2(MAX_RETRIES + 2) < 2) ? 2 : $clog2(MAX_RETRIES + 2);

    localparam logic [ACQ_W-1:0] ACQ_LAST   = ACQ_W'(ACQ_TIMEOUT - 1);
    localparam logic [BO_W-1:0]  BO_LAST    = BO_W'(BACKOFF_CYCLES - 1);
    localparam logic [FC_W-1:0]  FREQ_LAST  = FC_W'(FREQ_VIOL_LIMIT - 1);
    localparam logic [FC_W-1:0]  FREQ_MAX   = FC_W'(FREQ_VIOL_LIMIT);
    localparam logic [RW-1:0]    RETRY_SAT  = RW'(MAX_RETRIES + 1);
    localparam logic [RW-1:0]    RETRY_LIM  = RW'(MAX_RETRIES);
    localparam logic [RW-1:0]    RETRY_VIS  = RW'(3);

    state_t             state_q, state_d;
    logic [ACQ_W-1:0]   acq_tmr_q, acq_tmr_d;
    logic [BO_W-1:0]    bo_tmr_q, bo_tmr_d;
    logic [FC_W-1:0]    freq_cnt_q, freq_cnt_d;
    logic [RW-1:0]      retry_q, retry_d;
    logic [1:0]         code_q, code_d;
    logic [CYCLE_W-1:0] count_q, count_d;
    logic               frame_q, frame_d;
    logic               idle_q, idle_d;
    logic               rec_en_q, locked_q, fault_q;
    logic               go_fault;
    logic [1:0]         new_code;

    always_comb begin
        state_d    = state_q;
        acq_tmr_d  = acq_tmr_q;
        bo_tmr_d   = bo_tmr_q;
        freq_cnt_d = freq_cnt_q;
        retry_d    = retry_q;
        code_d     = code_q;
        count_d    = count_q;
        frame_d    = 1'b0;
        idle_d     = idle_q;
        go_fault   = 1'b0;
        new_code   = 2'd0;

        case (state_q)
            ST_DISABLED: begin
                if (ctrl_enable_i) state_d = ST_CONFIG;
            end
            ST_CONFIG: begin
                count_d   = preemptive_cfg_i;
                acq_tmr_d = '0;
                state_d   = ST_ACQUIRE;
            end
            ST_ACQUIRE: begin
                if (long_pause_complete_i) begin
                    state_d    = ST_LOCKED;
                    freq_cnt_d = '0;
                    idle_d     = 1'b0;
                end else if (acq_tmr_q == ACQ_LAST) begin
                    go_fault = 1'b1;
                    new_code = 2'd1;
                end else begin
                    acq_tmr_d = acq_tmr_q + 1'b1;
                end
            end
            ST_LOCKED: begin
                if (data_overflow_violation_i || data_underflow_violation_i) begin
                    go_fault = 1'b1;
                    new_code = 2'd2;
                end else if (frequency_violation_i && freq_cnt_q == FREQ_LAST) begin
                    go_fault = 1'b1;
                    new_code = 2'd3;
                end else begin
                    if (short_pause_complete_i) begin
                        frame_d    = 1'b1;
                        freq_cnt_d = '0;
                    end else if (frequency_violation_i && freq_cnt_q != FREQ_MAX) begin
                        freq_cnt_d = freq_cnt_q + 1'b1;
                    end
                    if (long_pause_complete_i)       idle_d = 1'b1;
                    else if (pause_start_detected_i) idle_d = 1'b0;
                end
            end
            ST_FAULT: begin
                if (bo_tmr_q == BO_LAST) begin
                    state_d = (retry_q <= RETRY_LIM) ? ST_CONFIG : ST_HALT;
                end else begin
                    bo_tmr_d = bo_tmr_q + 1'b1;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: state_d = ST_DISABLED;
        endcase

        if (go_fault) begin
            state_d  = ST_FAULT;
            bo_tmr_d = '0;
            code_d   = new_code;
            retry_d  = (retry_q == RETRY_SAT) ? retry_q : retry_q + 1'b1;
            idle_d   = 1'b0;
            frame_d  = 1'b0;
        end

        // Dropping the CSR enable overrides everything, including a same-cycle fault.
        if (!ctrl_enable_i) begin
            state_d    = ST_DISABLED;
            retry_d    = '0;
            code_d     = 2'd0;
            frame_d    = 1'b0;
            idle_d     = 1'b0;
            acq_tmr_d  = '0;
            bo_tmr_d   = '0;
            freq_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            state_q    <= ST_DISABLED;
            acq_tmr_q  <= '0;
            bo_tmr_q   <= '0;
            freq_cnt_q <= '0;
            retry_q    <= '0;
            code_q     <= 2'd0;
            count_q    <= '0;
            frame_q    <= 1'b0;
            idle_q     <= 1'b0;
            rec_en_q   <= 1'b0;
            locked_q   <= 1'b0;
            fault_q    <= 1'b0;
        end else if (clk_en) begin
            state_q    <= state_d;
            acq_tmr_q  <= acq_tmr_d;
            bo_tmr_q   <= bo_tmr_d;
            freq_cnt_q <= freq_cnt_d;
            retry_q    <= retry_d;
            code_q     <= code_d;
            count_q    <= count_d;
            frame_q    <= frame_d;
            idle_q     <= idle_d;
            rec_en_q   <= (state_d == ST_ACQUIRE) || (state_d == ST_LOCKED);
            locked_q   <= (state_d == ST_LOCKED);
            fault_q    <= (state_d == ST_FAULT) || (state_d == ST_HALT);
        end
    end

    assign recovery_enable_o               = rec_en_q;
    assign preemptive_output_cycle_count_o = count_q;
    assign link_locked_o                   = locked_q;
    assign frame_end_o                     = frame_q;
    assign link_idle_o                     = idle_q;
    assign fault_o                         = fault_q;
    assign fault_code_o                    = code_q;
    assign retry_count_o                   = (retry_q > RETRY_VIS) ? 2'd3 : retry_q[1:0];
    assign state_o                         = state_q;

endmodule

// File: tb/tb_clock_recovery_sequencer.sv
// Directed bench for clock_recovery_sequencer: lock, framing, fault codes, backoff,
// retry/halt sequencing, clk_en freeze and async reset.
module tb_clock_recovery_sequencer;

    localparam logic [2:0] S_DISABLED = 3'd0;
    localparam logic [2:0] S_CONFIG   = 3'd1;
    localparam logic [2:0] S_ACQUIRE  = 3'd2;
    localparam logic [2:0] S_LOCKED   = 3'd3;
    localparam logic [2:0] S_FAULT    = 3'd4;
    localparam logic [2:0] S_HALT     = 3'd5;

    logic       clk;
    logic       async_rst_n;
    logic       clk_en;
    logic       ctrl_enable;
    logic [7:0] cfg;
    logic       pause_start, short_pause, long_pause;
    logic       overflow, underflow, freq_viol;
    logic       rec_en;
    logic [7:0] count;
    logic       locked, frame_end, idle, fault;
    logic [1:0] code, retry;
    logic [2:0] state;

    int checks;
    int errors;

    clock_recovery_sequencer dut (
        .clk                             (clk),
        .async_rst_n                     (async_rst_n),
        .clk_en                          (clk_en),
        .ctrl_enable_i                   (ctrl_enable),
        .preemptive_cfg_i                (cfg),
        .pause_start_detected_i          (pause_start),
        .short_pause_complete_i          (short_pause),
        .long_pause_complete_i           (long_pause),
        .data_overflow_violation_i       (overflow),
        .data_underflow_violation_i      (underflow),
        .frequency_violation_i           (freq_viol),
        .recovery_enable_o               (rec_en),
        .preemptive_output_cycle_count_o (count),
        .link_locked_o                   (locked),
        .frame_end_o                     (frame_end),
        .link_idle_o                     (idle),
        .fault_o                         (fault),
        .fault_code_o                    (code),
        .retry_count_o                   (retry),
        .state_o                         (state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        async_rst_n = 1'b0;
        clk_en      = 1'b0;
        ctrl_enable = 1'b0;
        cfg         = 8'd0;
        pause_start = 1'b0;
        short_pause = 1'b0;
        long_pause  = 1'b0;
        overflow    = 1'b0;
        underflow   = 1'b0;
        freq_viol   = 1'b0;
        step(3);

        check("rst_state",  32'(state),  32'(S_DISABLED));
        check("rst_en",     32'(rec_en), 0);
        check("rst_count",  32'(count),  0);
        check("rst_locked", 32'(locked), 0);
        check("rst_fault",  32'(fault),  0);
        check("rst_retry",  32'(retry),  0);

        // Lock sequence: enable, cfg=5, long pause around cycle 20
        async_rst_n = 1'b1;
        clk_en      = 1'b1;
        ctrl_enable = 1'b1;
        cfg         = 8'd5;
        step(1);
        check("c1_state",  32'(state),  32'(S_CONFIG));
        check("c1_en",     32'(rec_en), 0);
        step(1);
        check("c2_state",  32'(state),  32'(S_ACQUIRE));
        check("c2_count",  32'(count),  5);
        check("c2_en",     32'(rec_en), 1);
        step(17);
        long_pause = 1'b1;
        step(1);
        long_pause = 1'b0;
        cfg        = 8'd7;
        check("lock_state",  32'(state),  32'(S_LOCKED));
        check("lock_locked", 32'(locked), 1);
        check("lock_idle",   32'(idle),   0);

        long_pause = 1'b1;
        step(1);
        long_pause = 1'b0;
        check("idle_set", 32'(idle), 1);
        pause_start = 1'b1;
        step(1);
        pause_start = 1'b0;
        check("idle_clr", 32'(idle), 0);

        // Three violations then a short pause: stays locked, frame pulse
        freq_viol = 1'b1;
        step(3);
        freq_viol = 1'b0;
        check("fv3_locked", 32'(locked), 1);
        short_pause = 1'b1;
        step(1);
        short_pause = 1'b0;
        check("frame_pulse",  32'(frame_end), 1);
        check("frame_locked", 32'(locked),    1);
        step(1);
        check("frame_drop", 32'(frame_end), 0);

        // Four violations in one frame -> fault code 3
        freq_viol = 1'b1;
        step(3);
        check("fv_pre_locked", 32'(locked), 1);
        step(1);
        freq_viol = 1'b0;
        check("fv4_fault",  32'(fault),  1);
        check("fv4_code",   32'(code),   3);
        check("fv4_en",     32'(rec_en), 0);
        check("fv4_locked", 32'(locked), 0);
        check("fv4_retry",  32'(retry),  1);
        check("fv4_count",  32'(count),  5);

        // Backoff with clk_en low for 10 cycles: 64 enabled cycles total
        step(20);
        clk_en = 1'b0;
        step(10);
        check("freeze_state", 32'(state), 32'(S_FAULT));
        clk_en = 1'b1;
        step(43);
        check("bo63_fault", 32'(fault), 1);
        step(1);
        check("bo64_state", 32'(state), 32'(S_CONFIG));
        check("bo64_fault", 32'(fault), 0);
        step(1);
        check("relatch_count", 32'(count),  7);
        check("reacq_en",      32'(rec_en), 1);

        // Overflow + freq violation + short pause together -> code 2, no frame pulse
        long_pause = 1'b1;
        step(1);
        long_pause = 1'b0;
        check("relock", 32'(locked), 1);
        freq_viol = 1'b1;
        step(3);
        overflow    = 1'b1;
        short_pause = 1'b1;
        step(1);
        overflow    = 1'b0;
        short_pause = 1'b0;
        freq_viol   = 1'b0;
        check("ovf_code",  32'(code),      2);
        check("ovf_frame", 32'(frame_end), 0);
        check("ovf_fault", 32'(fault),     1);
        check("ovf_retry", 32'(retry),     2);
        step(64);
        check("ovf_bo_state", 32'(state), 32'(S_CONFIG));
        step(1);

        // Disable clears retry and code
        ctrl_enable = 1'b0;
        step(1);
        check("dis_state", 32'(state),  32'(S_DISABLED));
        check("dis_retry", 32'(retry),  0);
        check("dis_code",  32'(code),   0);
        check("dis_en",    32'(rec_en), 0);
        ctrl_enable = 1'b1;
        step(2);
        check("dis_reacq", 32'(state), 32'(S_ACQUIRE));

        // Four consecutive acquire timeouts -> HALT
        for (int r = 1; r <= 4; r++) begin
            step(1023);
            check("to_pre_en", 32'(rec_en), 1);
            step(1);
            check("to_fault", 32'(fault), 1);
            check("to_code",  32'(code),  1);
            check("to_retry", 32'(retry), (r > 3) ? 3 : r);
            step(64);
            if (r < 4) begin
                check("to_cfg", 32'(state), 32'(S_CONFIG));
                step(1);
            end else begin
                check("to_halt",       32'(state), 32'(S_HALT));
                check("to_halt_fault", 32'(fault), 1);
            end
        end
        step(5);
        check("halt_hold", 32'(state), 32'(S_HALT));
        ctrl_enable = 1'b0;
        step(1);
        check("halt_dis",       32'(state), 32'(S_DISABLED));
        check("halt_dis_fault", 32'(fault), 0);
        ctrl_enable = 1'b1;
        step(1);
        check("halt_cfg",       32'(state), 32'(S_CONFIG));
        check("halt_cfg_retry", 32'(retry), 0);
        step(1);
        check("halt_reacq_en", 32'(rec_en), 1);

        // Asynchronous reset mid-cycle drops recovery_enable immediately
        #3;
        async_rst_n = 1'b0;
        #1;
        check("arst_en",    32'(rec_en), 0);
        check("arst_state", 32'(state),  32'(S_DISABLED));
        step(1);
        async_rst_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
